circuit1_pipe: RTL

Parametrised, pipelined successor to the Circuit1 datapath. It computes the same operation graph at any width: signed add, add, compare, select, signed multiply, signed subtract. The compare operator is selectable, and the block has valid/ready handshakes on both sides with full back-pressure support. It sits between a producer and consumer of operand triples in generated datapath designs where a single output register is not enough.

---
 rtl/circuit1_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/circuit1_pipe.sv
// -----------------------------------------------------------------------------
// circuit1_pipe
//   Two-stage pipelined Circuit1 datapath with valid/ready handshakes.
//   Stage 1 registers d = a+b, e = a+c (both mod 2^W) and the full signed
//   product f = a*c. Stage 2 registers z = g ? e : d, where g is the
//   compare selected by CMP_MODE, and x = f - sign_extend(d) (mod 2^2W).
//
// Parameters
//   W         operand width (>= 2); z is W bits, x is 2W bits
//   CMP_MODE  0: d>e, 1: d<e, 2: d==e, anything else behaves as 0
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   a, b, c    signed W-bit operands
//   in_valid   producer presents a/b/c
//   in_ready   block accepts a/b/c (combinational from stage state + out_ready)
//   z          signed W-bit selected result
//   x          signed 2W-bit product-minus-sum result
//   out_valid  z/x valid
//   out_ready  consumer accepts z/x
// -----------------------------------------------------------------------------
module circuit1_pipe #(
    parameter int W        = 8,
    parameter int CMP_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    input  logic signed [W-1:0]   c,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic signed [W-1:0]   z,
    output logic signed [2*W-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready
);

    // Compare of d against e, both treated as signed W-bit values.
    function automatic logic cmp_g(input logic signed [W-1:0] dv,
                                   input logic signed [W-1:0] ev);
        logic res;
        case (CMP_MODE)
            32'sd1:  res = (dv < ev);
            32'sd2:  res = (dv == ev);
            default: res = (dv > ev);
        endcase
        return res;
    endfunction

    logic                  v1_r;
    logic                  v2_r;
    logic signed [W-1:0]   d_r;
    logic signed [W-1:0]   e_r;
    logic signed [2*W-1:0] f_r;
    logic signed [W-1:0]   z_r;
    logic signed [2*W-1:0] x_r;

    logic                  adv1_s;
    logic                  adv2_s;
    logic signed [W-1:0]   d_s;
    logic signed [W-1:0]   e_s;
    logic signed [2*W-1:0] a_ext_s;
    logic signed [2*W-1:0] c_ext_s;
    logic signed [2*W-1:0] f_s;
    logic signed [2*W-1:0] d_ext_s;
    logic                  g_s;
    logic signed [W-1:0]   z_s;
    logic signed [2*W-1:0] x_s;

    // Advance conditions: an empty stage never blocks the one feeding it.
    // During reset both valids are low, so in_ready reads 1.
    always_comb begin
        adv2_s   = !v2_r || out_ready;
        adv1_s   = !v1_r || adv2_s;
        in_ready = adv1_s;
    end

    // Stage-1 arithmetic: wrapping sums and the untruncated 2W-bit product.
    always_comb begin
        d_s     = a + b;
        e_s     = a + c;
        a_ext_s = {{W{a[W-1]}}, a};
        c_ext_s = {{W{c[W-1]}}, c};
        f_s     = a_ext_s * c_ext_s;
    end

    // Stage-2 arithmetic: select and product-minus-sign-extended-sum.
    always_comb begin
        g_s     = cmp_g(d_r, e_r);
        z_s     = g_s ? e_r : d_r;
        d_ext_s = {{W{d_r[W-1]}}, d_r};
        x_s     = f_r - d_ext_s;
    end

    // Stage-1 registers: valid follows in_valid on advance, data loads only
    // on an actual input transfer so stalled contents are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            d_r  <= {W{1'b0}};
            e_r  <= {W{1'b0}};
            f_r  <= {(2*W){1'b0}};
        end else if (adv1_s) begin
            v1_r <= in_valid;
            if (in_valid) begin
                d_r <= d_s;
                e_r <= e_s;
                f_r <= f_s;
            end
        end
    end

    // Stage-2 registers: z/x load only when stage 1 holds a result, so the
    // outputs never change while out_valid is low or the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_r <= 1'b0;
            z_r  <= {W{1'b0}};
            x_r  <= {(2*W){1'b0}};
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                z_r <= z_s;
                x_r <= x_s;
            end
        end
    end

    assign z         = z_r;
    assign x         = x_r;
    assign out_valid = v2_r;

endmodule
